// File: rtl/pkg_heatctrl.sv
// Shared state encoding and defaults for the bubble memory heater sequencer.
// Holds the parameters that the top and timer agree on.
package pkg_heatctrl;

  typedef enum logic [2:0] {
    S_COLD   = 3'd0,
    S_HEAT   = 3'd1,
    S_SETTLE = 3'd2,
    S_READY  = 3'd3,
    S_DRAIN  = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam int SETTLE_TICKS_DEF = 4096;
  localparam int HEAT_TIMEOUT_DEF = 1048576;
  localparam int CNT_W_DEF        = 20;
  localparam int DROP_CNT_W       = 8;

  // The 2 MHz bubble clock only runs while an access can be live.
  function automatic logic clk_runs(input state_t s);
    return (s == S_READY) || (s == S_DRAIN);
  endfunction

endpackage

// File: rtl/mdl_heatctrl_timer.sv
// Tick counter for the heat/settle windows; hit is registered and means the
// count now equals term, so term must describe the state being entered.
module mdl_heatctrl_timer
  import pkg_heatctrl::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_MCLK,
  input  logic             i_RST,
  input  logic             cen,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;

  assign cnt_nxt = clr ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      cnt_q <= '0;
      hit   <= 1'b0;
    end else if (cen) begin
      cnt_q <= cnt_nxt;
      hit   <= (cnt_nxt == term);
    end
  end

endmodule

// File: rtl/mdl_heatctrl.sv
// Heater warm-up sequencer and single-access gate; all outputs registered, 1 tick latency.
// A temperature drop stops the bubble clock at once when idle, or after the live access completes.
module mdl_heatctrl
  import pkg_heatctrl::*;
#(
  parameter int SETTLE_TICKS = SETTLE_TICKS_DEF,
  parameter int HEAT_TIMEOUT = HEAT_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                  i_MCLK,
  input  logic                  i_RST,
  input  logic                  i_CLK4M_PCEN_n,
  input  logic                  i_TEMPDROP_SET_n,
  input  logic                  i_HEATEN_n,
  input  logic                  i_ACC_REQ,
  input  logic                  i_ACC_DONE,
  input  logic                  i_RETRY,
  output logic                  o_CLK2M_STOP_n,
  output logic                  o_ACC_GNT,
  output logic                  o_READY,
  output logic                  o_FAULT,
  output logic [DROP_CNT_W-1:0] o_DROP_CNT
);

  localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE_TICKS - 1);
  localparam logic [CNT_W-1:0] HEAT_TERM   = CNT_W'(HEAT_TIMEOUT - 1);

  state_t                state_q;
  state_t                state_nxt;
  logic                  tick;
  logic                  drop;
  logic                  done;
  logic                  gnt_nxt;
  logic                  mute_q;
  logic                  mute_nxt;
  logic [DROP_CNT_W-1:0] drop_cnt_nxt;
  logic                  tmr_clr;
  logic                  tmr_hit;
  logic [CNT_W-1:0]      tmr_term;

  assign tick = ~i_CLK4M_PCEN_n;
  assign drop = ~i_TEMPDROP_SET_n;
  assign done = o_ACC_GNT & i_ACC_DONE;

  always_comb begin
    state_nxt = state_q;
    gnt_nxt   = o_ACC_GNT;
    case (state_q)
      S_COLD: state_nxt = S_HEAT;
      S_HEAT: begin
        if (i_HEATEN_n)   state_nxt = S_SETTLE;
        else if (tmr_hit) state_nxt = S_FAULT;
      end
      S_SETTLE: begin
        if (!i_HEATEN_n)  state_nxt = S_HEAT;
        else if (tmr_hit) state_nxt = S_READY;
      end
      S_READY: begin
        if (done) begin
          gnt_nxt = 1'b0;
          if (drop) state_nxt = S_HEAT;
        end else if (drop) begin
          // An in-flight access must finish before the clock may stop.
          state_nxt = o_ACC_GNT ? S_DRAIN : S_HEAT;
        end else if (!o_ACC_GNT && i_ACC_REQ && !mute_q) begin
          gnt_nxt = 1'b1;
        end
      end
      S_DRAIN: begin
        if (done) begin
          gnt_nxt   = 1'b0;
          state_nxt = S_HEAT;
        end
      end
      S_FAULT: begin
        if (i_RETRY) state_nxt = S_COLD;
      end
      default: state_nxt = S_COLD;
    endcase
    if (!clk_runs(state_nxt)) gnt_nxt = 1'b0;
  end

  // Requester gets one tick after a grant drops to release its request.
  assign mute_nxt     = o_ACC_GNT & ~gnt_nxt;
  assign drop_cnt_nxt = (drop && (o_DROP_CNT != '1)) ? o_DROP_CNT + DROP_CNT_W'(1) : o_DROP_CNT;

  // Every entry into HEAT or SETTLE starts a fresh window.
  assign tmr_clr  = (state_nxt != state_q) ||
                    !((state_nxt == S_HEAT) || (state_nxt == S_SETTLE));
  assign tmr_term = (state_nxt == S_SETTLE) ? SETTLE_TERM : HEAT_TERM;

  mdl_heatctrl_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .i_MCLK (i_MCLK),
    .i_RST  (i_RST),
    .cen    (tick),
    .clr    (tmr_clr),
    .term   (tmr_term),
    .hit    (tmr_hit)
  );

  always_ff @(posedge i_MCLK) begin
    if (i_RST) begin
      state_q        <= S_COLD;
      mute_q         <= 1'b0;
      o_CLK2M_STOP_n <= 1'b0;
      o_ACC_GNT      <= 1'b0;
      o_READY        <= 1'b0;
      o_FAULT        <= 1'b0;
      o_DROP_CNT     <= '0;
    end else if (tick) begin
      state_q        <= state_nxt;
      mute_q         <= mute_nxt;
      o_CLK2M_STOP_n <= clk_runs(state_nxt);
      o_ACC_GNT      <= gnt_nxt;
      o_READY        <= (state_nxt == S_READY);
      o_FAULT        <= (state_nxt == S_FAULT);
      o_DROP_CNT     <= drop_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mdl_heatctrl.sv
// Bench for mdl_heatctrl: directed scenarios with fixed tick expectations,
// then randomized traffic against a behavioural model of the sequencer.
module tb_mdl_heatctrl;

  localparam int ST = 8;
  localparam int HT = 16;
  localparam int CW = 5;

  logic       i_MCLK = 1'b0;
  logic       i_RST;
  logic       i_CLK4M_PCEN_n;
  logic       i_TEMPDROP_SET_n;
  logic       i_HEATEN_n;
  logic       i_ACC_REQ;
  logic       i_ACC_DONE;
  logic       i_RETRY;
  logic       o_CLK2M_STOP_n;
  logic       o_ACC_GNT;
  logic       o_READY;
  logic       o_FAULT;
  logic [7:0] o_DROP_CNT;

  int checks   = 0;
  int failures = 0;

  always #5 i_MCLK = ~i_MCLK;

  mdl_heatctrl #(
    .SETTLE_TICKS (ST),
    .HEAT_TIMEOUT (HT),
    .CNT_W        (CW)
  ) dut (
    .i_MCLK           (i_MCLK),
    .i_RST            (i_RST),
    .i_CLK4M_PCEN_n   (i_CLK4M_PCEN_n),
    .i_TEMPDROP_SET_n (i_TEMPDROP_SET_n),
    .i_HEATEN_n       (i_HEATEN_n),
    .i_ACC_REQ        (i_ACC_REQ),
    .i_ACC_DONE       (i_ACC_DONE),
    .i_RETRY          (i_RETRY),
    .o_CLK2M_STOP_n   (o_CLK2M_STOP_n),
    .o_ACC_GNT        (o_ACC_GNT),
    .o_READY          (o_READY),
    .o_FAULT          (o_FAULT),
    .o_DROP_CNT       (o_DROP_CNT)
  );

  // Behavioural model: phase name, elapsed ticks in phase, grant flag, drop tally.
  typedef enum int {M_COLD, M_HEAT, M_SETTLE, M_READY, M_DRAIN, M_FAULT} mstate_t;
  mstate_t m_st;
  int      m_timer;
  bit      m_gnt;
  bit      m_mute;
  int      m_drops;

  task automatic model_reset();
    m_st = M_COLD; m_timer = 0; m_gnt = 0; m_mute = 0; m_drops = 0;
  endtask

  task automatic model_edge();
    bit drop, done, mute_now;
    if (i_RST) begin
      model_reset();
      return;
    end
    if (i_CLK4M_PCEN_n) return;
    drop     = !i_TEMPDROP_SET_n;
    done     = m_gnt && i_ACC_DONE;
    mute_now = m_mute;
    m_mute   = 0;
    if (drop && m_drops < 255) m_drops++;
    case (m_st)
      M_COLD: begin m_st = M_HEAT; m_timer = 0; end
      M_HEAT: begin
        if (i_HEATEN_n) begin m_st = M_SETTLE; m_timer = 0; end
        else if (m_timer == HT - 1) m_st = M_FAULT;
        else m_timer++;
      end
      M_SETTLE: begin
        if (!i_HEATEN_n) begin m_st = M_HEAT; m_timer = 0; end
        else if (m_timer == ST - 1) m_st = M_READY;
        else m_timer++;
      end
      M_READY: begin
        if (done) begin
          m_gnt = 0; m_mute = 1;
          if (drop) begin m_st = M_HEAT; m_timer = 0; end
        end else if (drop) begin
          if (m_gnt) m_st = M_DRAIN;
          else begin m_st = M_HEAT; m_timer = 0; end
        end else if (!m_gnt && i_ACC_REQ && !mute_now) begin
          m_gnt = 1;
        end
      end
      M_DRAIN: begin
        if (done) begin m_gnt = 0; m_st = M_HEAT; m_timer = 0; end
      end
      M_FAULT: if (i_RETRY) m_st = M_COLD;
      default: m_st = M_COLD;
    endcase
  endtask

  function automatic logic [11:0] model_out();
    return {(m_st == M_READY) || (m_st == M_DRAIN), m_gnt, m_st == M_READY,
            m_st == M_FAULT, 8'(m_drops)};
  endfunction

  task automatic edge_step();
    @(posedge i_MCLK);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    i_RST = 0; i_CLK4M_PCEN_n = 0; i_TEMPDROP_SET_n = 1; i_HEATEN_n = 1;
    i_ACC_REQ = 0; i_ACC_DONE = 0; i_RETRY = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_RST = 1;
    edge_step();
    i_RST = 0;
  endtask

  task automatic bring_ready();
    do_reset();
    for (int c = 0; c < 40 && m_st != M_READY; c++) edge_step();
    checks++;
    if (o_READY !== 1'b1) begin
      failures++;
      $display("FAIL bring_ready o_READY=%b want 1", o_READY);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    i_CLK4M_PCEN_n = 1;
    i_RST = 1;
    edge_step();
    edge_step();
    checks++;
    if ({o_CLK2M_STOP_n, o_ACC_GNT, o_READY, o_FAULT, o_DROP_CNT} !== 12'h000) begin
      failures++;
      $display("FAIL reset outs=%h want 000", {o_CLK2M_STOP_n, o_ACC_GNT, o_READY, o_FAULT, o_DROP_CNT});
    end
  endtask

  task automatic test_warmup();
    int tick;
    int rdy_tick;
    bit exp;
    do_reset();
    tick = 0;
    rdy_tick = -1;
    for (int c = 0; c < 30; c++) begin
      i_CLK4M_PCEN_n = (c % 2 == 1);
      edge_step();
      if (!i_CLK4M_PCEN_n) tick++;
      exp = (tick >= ST + 2);
      checks++;
      if ({o_CLK2M_STOP_n, o_READY} !== {exp, exp}) begin
        failures++;
        $display("FAIL warmup tick=%0d stop_n/ready=%b%b want %b%b", tick, o_CLK2M_STOP_n, o_READY, exp, exp);
      end
      if (o_READY === 1'b1 && rdy_tick < 0) rdy_tick = tick;
    end
    checks++;
    if (rdy_tick !== ST + 2) begin
      failures++;
      $display("FAIL warmup_latency ready at tick %0d want %0d", rdy_tick, ST + 2);
    end
  endtask

  task automatic test_heat_timeout();
    do_reset();
    i_HEATEN_n = 0;
    for (int t = 1; t <= 20; t++) begin
      edge_step();
      checks++;
      if (o_FAULT !== (t >= HT + 1)) begin
        failures++;
        $display("FAIL heat_timeout tick=%0d o_FAULT=%b want %b", t, o_FAULT, (t >= HT + 1));
      end
    end
    i_RETRY = 1;
    edge_step();
    i_RETRY = 0;
    checks++;
    if ({o_FAULT, o_CLK2M_STOP_n} !== 2'b00) begin
      failures++;
      $display("FAIL retry fault/stop_n=%b%b want 00", o_FAULT, o_CLK2M_STOP_n);
    end
    edge_step();
    checks++;
    if (o_FAULT !== 1'b0) begin
      failures++;
      $display("FAIL retry_heat o_FAULT=%b want 0", o_FAULT);
    end
  endtask

  task automatic test_settle_glitch();
    do_reset();
    for (int t = 1; t <= 20; t++) begin
      i_HEATEN_n = (t != 5);
      edge_step();
      checks++;
      if (o_READY !== (t >= 14)) begin
        failures++;
        $display("FAIL settle_glitch tick=%0d o_READY=%b want %b", t, o_READY, (t >= 14));
      end
    end
  endtask

  task automatic test_drain();
    bring_ready();
    for (int t = 1; t <= 10; t++) begin
      i_ACC_REQ = 1;
      i_TEMPDROP_SET_n = (t != 3);
      i_ACC_DONE = (t == 6);
      edge_step();
      checks++;
      if ({o_ACC_GNT, o_CLK2M_STOP_n, o_READY} !== {t <= 5, t <= 5, t <= 2}) begin
        failures++;
        $display("FAIL drain tick=%0d gnt/stop_n/ready=%b%b%b want %b%b%b", t, o_ACC_GNT,
                 o_CLK2M_STOP_n, o_READY, t <= 5, t <= 5, t <= 2);
      end
    end
    idle_inputs();
    checks++;
    if (o_DROP_CNT !== 8'd1) begin
      failures++;
      $display("FAIL drain_dropcnt o_DROP_CNT=%0d want 1", o_DROP_CNT);
    end
  endtask

  task automatic test_back_to_back();
    bring_ready();
    for (int t = 1; t <= 5; t++) begin
      i_ACC_REQ = 1;
      i_ACC_DONE = (t == 2 || t == 5);
      edge_step();
      checks++;
      if (o_ACC_GNT !== (t == 1 || t == 4)) begin
        failures++;
        $display("FAIL back_to_back tick=%0d gnt=%b want %b", t, o_ACC_GNT, (t == 1 || t == 4));
      end
    end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    bring_ready();
    i_ACC_REQ = 1;
    i_TEMPDROP_SET_n = 0;
    edge_step();
    i_TEMPDROP_SET_n = 1;
    checks++;
    if ({o_ACC_GNT, o_CLK2M_STOP_n, o_READY} !== 3'b000) begin
      failures++;
      $display("FAIL drop_req gnt/stop_n/ready=%b%b%b want 000", o_ACC_GNT, o_CLK2M_STOP_n, o_READY);
    end
    edge_step();
    checks++;
    if (o_ACC_GNT !== 1'b0) begin
      failures++;
      $display("FAIL drop_req_heat gnt=%b want 0", o_ACC_GNT);
    end
    bring_ready();
    i_ACC_REQ = 1;
    edge_step();
    checks++;
    if (o_ACC_GNT !== 1'b1) begin
      failures++;
      $display("FAIL drop_done_grant gnt=%b want 1", o_ACC_GNT);
    end
    i_TEMPDROP_SET_n = 0;
    i_ACC_DONE = 1;
    edge_step();
    idle_inputs();
    i_ACC_REQ = 1;
    checks++;
    if ({o_ACC_GNT, o_CLK2M_STOP_n} !== 2'b00) begin
      failures++;
      $display("FAIL drop_done gnt/stop_n=%b%b want 00", o_ACC_GNT, o_CLK2M_STOP_n);
    end
    edge_step();
    idle_inputs();
    checks++;
    if ({o_ACC_GNT, o_CLK2M_STOP_n} !== 2'b00) begin
      failures++;
      $display("FAIL drop_done_nodrain gnt/stop_n=%b%b want 00", o_ACC_GNT, o_CLK2M_STOP_n);
    end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      i_TEMPDROP_SET_n = (i % 2 == 1);
      edge_step();
      if (i == 199 || i == 506 || i == 599) begin
        int want;
        want = (i / 2 + 1 > 255) ? 255 : i / 2 + 1;
        checks++;
        if (o_DROP_CNT !== 8'(want)) begin
          failures++;
          $display("FAIL drop_sat cycle=%0d o_DROP_CNT=%0d want %0d", i, o_DROP_CNT, want);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_grant();
    bring_ready();
    i_ACC_REQ = 1;
    edge_step();
    i_TEMPDROP_SET_n = 0;
    edge_step();
    i_TEMPDROP_SET_n = 1;
    checks++;
    if ({o_ACC_GNT, o_DROP_CNT} !== {1'b1, 8'd1}) begin
      failures++;
      $display("FAIL pre_reset gnt=%b cnt=%0d want 1 1", o_ACC_GNT, o_DROP_CNT);
    end
    i_RST = 1;
    i_CLK4M_PCEN_n = 1;
    edge_step();
    checks++;
    if ({o_CLK2M_STOP_n, o_ACC_GNT, o_READY, o_FAULT, o_DROP_CNT} !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid_grant outs=%h want 000", {o_CLK2M_STOP_n, o_ACC_GNT, o_READY, o_FAULT, o_DROP_CNT});
    end
    idle_inputs();
  endtask

  task automatic test_random();
    bit heat_on;
    logic [11:0] act;
    logic [11:0] exp;
    int bad;
    do_reset();
    heat_on = 0;
    bad = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 59) == 0) heat_on = !heat_on;
      i_RST            = ($urandom_range(0, 499) == 0);
      i_CLK4M_PCEN_n   = ($urandom_range(0, 3) == 0);
      i_TEMPDROP_SET_n = !($urandom_range(0, 39) == 0);
      i_HEATEN_n       = !heat_on;
      i_ACC_REQ        = ($urandom_range(0, 2) != 0);
      i_ACC_DONE       = ($urandom_range(0, 4) == 0);
      i_RETRY          = ($urandom_range(0, 19) == 0);
      edge_step();
      act = {o_CLK2M_STOP_n, o_ACC_GNT, o_READY, o_FAULT, o_DROP_CNT};
      exp = model_out();
      checks++;
      if (act !== exp) begin
        failures++;
        if (bad < 10)
          $display("FAIL random cycle=%0d stop_n/gnt/ready/fault/cnt=%h want %h", c, act, exp);
        bad++;
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_warmup();
    test_heat_timeout();
    test_settle_glitch();
    test_drain();
    test_back_to_back();
    test_simultaneous();
    test_drop_saturation();
    test_reset_mid_grant();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
